safebox_lock_ctrl: RTL and testbench

Keypad-facing lock controller for the 4-digit safe box. It collects 4-bit digit keys, compares the entry against a stored code, and drives the unlock output. It counts consecutive failures and raises `alarm`, which feeds the downstream alarm LED/buzzer stage directly. It also supports a code change while the box is unlocked.

---
 rtl/safebox_pkg.sv | 21 ++
 rtl/safebox_lock_ctrl_timer.sv | 34 +++
 rtl/safebox_lock_ctrl.sv | 177 +++++++++++++++++
 tb/tb_safebox_lock_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/safebox_pkg.sv
// Shared state encoding, keypad codes and key classification for the safe-box lock controller.
package safebox_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_UNLOCKED,
      ST_SETPW,
      ST_ALARM
   } state_t;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_CLR   = 4'hB;
   localparam logic [3:0] KEY_SET   = 4'hC;
   localparam logic [3:0] KEY_LOCK  = 4'hD;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

endpackage

// File: rtl/safebox_lock_ctrl_timer.sv
// Loadable down-counter that saturates at zero; load value appears one cycle after load.
// No backpressure: load wins over decrement, and the count simply holds once at zero.
module lock_timer #(
   parameter int TMR_W = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic [TMR_W-1:0] count,
   output logic             zero
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - TMR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign count = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/safebox_lock_ctrl.sv
// Keypad lock FSM: 4-digit entry, code compare, unlock window, code change, failure alarm.
// Outputs registered; unlock rises 2 cycles after ENTER; keys are single-cycle strobes, no backpressure.
module safebox_lock_ctrl
   import safebox_pkg::*;
#(
   parameter logic [15:0] DEFAULT_PW    = 16'h1234,
   parameter int          MAX_FAIL      = 3,
   parameter int          UNLOCK_CYCLES = 8_000_000,
   parameter int          ALARM_CYCLES  = 48_000_000,
   parameter int          TMR_W         = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_vld,
   input  logic [3:0] key_code,
   input  logic       admin_clr,
   output logic       unlock,
   output logic       alarm,
   output logic [1:0] fail_cnt,
   output logic [2:0] digit_cnt,
   output logic       busy_set
);

   state_t           state_q;
   logic [15:0]      pw_q;
   logic [15:0]      entry_q;
   logic [2:0]       digit_cnt_q;
   logic [1:0]       fail_cnt_q;
   logic             unlock_q, alarm_q, busy_set_q;

   logic             tmr_load, tmr_zero;
   logic [TMR_W-1:0] tmr_val;
   logic [TMR_W-1:0] tmr_cnt_unused;

   logic             key_ok, pw_match, entry_full;
   logic [1:0]       fail_inc;

   // admin_clr shadows any key strobe arriving in the same cycle
   assign key_ok     = key_vld & ~admin_clr;
   assign entry_full = (digit_cnt_q == 3'd4);
   assign pw_match   = entry_full && (entry_q == pw_q);
   assign fail_inc   = fail_cnt_q + 2'd1;

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_CHECK: begin
            if (pw_match) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(UNLOCK_CYCLES - 1);
            end else if (fail_inc == 2'(MAX_FAIL)) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(ALARM_CYCLES - 1);
            end
         end
         ST_SETPW: begin
            if (!tmr_zero && key_ok && key_code == KEY_ENTER && entry_full) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(UNLOCK_CYCLES - 1);
            end
         end
         default: ;
      endcase
   end

   lock_timer #(.TMR_W(TMR_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_cnt_unused),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pw_q        <= DEFAULT_PW;
         entry_q     <= '0;
         digit_cnt_q <= '0;
         fail_cnt_q  <= '0;
         unlock_q    <= 1'b0;
         alarm_q     <= 1'b0;
         busy_set_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (admin_clr)
                  fail_cnt_q <= '0;
               if (key_ok) begin
                  if (is_digit(key_code)) begin
                     if (!entry_full) begin
                        entry_q     <= {entry_q[11:0], key_code};
                        digit_cnt_q <= digit_cnt_q + 3'd1;
                     end
                  end else if (key_code == KEY_CLR) begin
                     entry_q     <= '0;
                     digit_cnt_q <= '0;
                  end else if (key_code == KEY_ENTER) begin
                     state_q <= ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               entry_q     <= '0;
               digit_cnt_q <= '0;
               if (pw_match) begin
                  state_q    <= ST_UNLOCKED;
                  fail_cnt_q <= '0;
                  unlock_q   <= 1'b1;
               end else if (fail_inc == 2'(MAX_FAIL)) begin
                  state_q    <= ST_ALARM;
                  fail_cnt_q <= fail_inc;
                  alarm_q    <= 1'b1;
               end else begin
                  state_q    <= ST_IDLE;
                  fail_cnt_q <= fail_inc;
               end
            end
            ST_UNLOCKED: begin
               if (admin_clr)
                  fail_cnt_q <= '0;
               if (tmr_zero || (key_ok && key_code == KEY_LOCK)) begin
                  state_q  <= ST_IDLE;
                  unlock_q <= 1'b0;
               end else if (key_ok && key_code == KEY_SET) begin
                  state_q    <= ST_SETPW;
                  busy_set_q <= 1'b1;
               end
            end
            ST_SETPW: begin
               if (admin_clr)
                  fail_cnt_q <= '0;
               if (tmr_zero || (key_ok && key_code == KEY_LOCK)) begin
                  state_q     <= ST_IDLE;
                  unlock_q    <= 1'b0;
                  busy_set_q  <= 1'b0;
                  entry_q     <= '0;
                  digit_cnt_q <= '0;
               end else if (key_ok) begin
                  if (is_digit(key_code)) begin
                     if (!entry_full) begin
                        entry_q     <= {entry_q[11:0], key_code};
                        digit_cnt_q <= digit_cnt_q + 3'd1;
                     end
                  end else if (key_code == KEY_CLR) begin
                     entry_q     <= '0;
                     digit_cnt_q <= '0;
                  end else if (key_code == KEY_ENTER && entry_full) begin
                     pw_q        <= entry_q;
                     state_q     <= ST_UNLOCKED;
                     busy_set_q  <= 1'b0;
                     entry_q     <= '0;
                     digit_cnt_q <= '0;
                  end
               end
            end
            ST_ALARM: begin
               if (admin_clr || tmr_zero) begin
                  state_q    <= ST_IDLE;
                  fail_cnt_q <= '0;
                  alarm_q    <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign unlock    = unlock_q;
   assign alarm     = alarm_q;
   assign fail_cnt  = fail_cnt_q;
   assign digit_cnt = digit_cnt_q;
   assign busy_set  = busy_set_q;

endmodule

// File: tb/tb_safebox_lock_ctrl.sv
// Bench for safebox_lock_ctrl: each ENTER pushes the modelled outcome, popped when the result registers.
module tb_safebox_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_vld;
   logic [3:0] key_code;
   logic       admin_clr;
   logic       unlock, alarm, busy_set;
   logic [1:0] fail_cnt;
   logic [2:0] digit_cnt;

   typedef struct {
      logic       unlock;
      logic       alarm;
      logic [1:0] fail;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [15:0] m_pw  = 16'h1234;
   int          m_fail = 0;

   safebox_lock_ctrl #(
      .DEFAULT_PW    (16'h1234),
      .MAX_FAIL      (3),
      .UNLOCK_CYCLES (20),
      .ALARM_CYCLES  (40),
      .TMR_W         (26)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_vld   (key_vld),
      .key_code  (key_code),
      .admin_clr (admin_clr),
      .unlock    (unlock),
      .alarm     (alarm),
      .fail_cnt  (fail_cnt),
      .digit_cnt (digit_cnt),
      .busy_set  (busy_set)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      key_vld  = 1'b1;
      key_code = k;
      @(negedge clk);
      key_vld  = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_unlock"}, 32'(unlock), 32'd0);
      chk({tag, "_alarm"},  32'(alarm), 32'd0);
      chk({tag, "_fail"},   32'(fail_cnt), 32'd0);
      chk({tag, "_digit"},  32'(digit_cnt), 32'd0);
      chk({tag, "_busy"},   32'(busy_set), 32'd0);
   endtask

   // Digits packed MSB-first in digs, n of them; modelled outcome queued at ENTER.
   task automatic attempt(input string tag, input logic [31:0] digs, input int n);
      logic [15:0] e;
      logic [3:0]  k;
      int          c;
      exp_t        x, got;
      e = '0;
      c = 0;
      for (int i = n - 1; i >= 0; i--) begin
         k = digs[i*4 +: 4];
         press(k);
         if (c < 4) begin
            e = {e[11:0], k};
            c++;
         end
      end
      chk({tag, "_digits"}, 32'(digit_cnt), 32'(c));
      if (c == 4 && e == m_pw) begin
         m_fail = 0;
         x = '{1'b1, 1'b0, 2'd0};
      end else begin
         m_fail++;
         x = '{1'b0, (m_fail == 3), 2'(m_fail)};
      end
      sb.push_back(x);
      press(4'hA);
      chk({tag, "_lat"}, 32'(unlock | alarm), 32'd0);
      @(negedge clk);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         got = sb.pop_front();
         chk({tag, "_unlock"}, 32'(unlock), 32'(got.unlock));
         chk({tag, "_alarm"},  32'(alarm), 32'(got.alarm));
         chk({tag, "_fail"},   32'(fail_cnt), 32'(got.fail));
      end
   endtask

   task automatic hold_len(input string tag, input bit sel_alarm, input int start, input int expct);
      int cnt;
      cnt = start;
      while ((sel_alarm ? alarm : unlock) && cnt < 500) begin
         cnt++;
         @(negedge clk);
      end
      chk(tag, 32'(cnt), 32'(expct));
   endtask

   initial begin
      rst_n     = 1'b0;
      key_vld   = 1'b0;
      key_code  = 4'h0;
      admin_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      attempt("ok1234", 32'h1234, 4);
      hold_len("unlock_len", 1'b0, 0, 20);
      chk("after_unlock_fail", 32'(fail_cnt), 32'd0);

      attempt("bad1", 32'h1235, 4);
      attempt("bad2", 32'h1235, 4);
      attempt("bad3", 32'h1235, 4);
      press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hA);
      chk("alarm_ign_alarm",  32'(alarm), 32'd1);
      chk("alarm_ign_unlock", 32'(unlock), 32'd0);
      chk("alarm_ign_digits", 32'(digit_cnt), 32'd0);
      hold_len("alarm_len", 1'b1, 5, 40);
      chk("alarm_end_fail", 32'(fail_cnt), 32'd0);
      m_fail = 0;

      attempt("bad4", 32'h1235, 4);
      attempt("bad5", 32'h1235, 4);
      attempt("bad6", 32'h1235, 4);
      admin_clr = 1'b1;
      key_vld   = 1'b1;
      key_code  = 4'hA;
      @(negedge clk);
      admin_clr = 1'b0;
      key_vld   = 1'b0;
      chk("admin_alarm",  32'(alarm), 32'd0);
      chk("admin_fail",   32'(fail_cnt), 32'd0);
      @(negedge clk);
      chk("admin_keydrop", 32'(fail_cnt), 32'd0);
      chk("admin_unlock",  32'(unlock), 32'd0);
      m_fail = 0;

      attempt("ok_pre_set", 32'h1234, 4);
      press(4'hC);
      chk("set_busy",   32'(busy_set), 32'd1);
      chk("set_unlock", 32'(unlock), 32'd1);
      press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'hA);
      m_pw = 16'h9876;
      chk("set_done_busy",   32'(busy_set), 32'd0);
      chk("set_done_unlock", 32'(unlock), 32'd1);
      press(4'hD);
      chk("lock_unlock", 32'(unlock), 32'd0);
      attempt("old_pw", 32'h1234, 4);
      attempt("new_pw", 32'h9876, 4);
      press(4'hD);

      attempt("pre_rst_set", 32'h9876, 4);
      press(4'hC);
      press(4'h1);
      chk("mid_set_busy", 32'(busy_set), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rst_setpw");
      m_pw   = 16'h1234;
      m_fail = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      attempt("five_dig", 32'h12345, 5);
      press(4'hD);
      attempt("short", 32'h12, 2);
      attempt("ok_clr_fail", 32'h1234, 4);
      press(4'hD);

      attempt("bad7", 32'h1235, 4);
      attempt("bad8", 32'h1235, 4);
      attempt("bad9", 32'h1235, 4);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("rst_alarm");
      m_fail = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      attempt("post_rst_ok", 32'h1234, 4);
      press(4'hD);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
